// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg: shared constants and types for the sequential multiplier slice.
//   MUL_W     : operand width in bits
//   MUL_PW    : product width (2 * MUL_W)
//   MUL_CNT_W : row-counter width, 2**MUL_CNT_W >= MUL_W
//   mul_state_t : controller states IDLE / ACCUM / DONE
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_W     = 6;
    localparam int MUL_PW    = 2 * MUL_W;
    localparam int MUL_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/pp_row_gen.sv
// -----------------------------------------------------------------------------
// pp_row_gen: one partial-product row, already aligned to its weight.
//   a_bit : multiplier bit selecting this row
//   b     : multiplicand (W bits)
//   shift : row index / left-shift amount (CNT_W bits)
//   row   : ({W'b0, b} << shift) when a_bit is set, else zero (2W bits)
// Purely combinational.
// -----------------------------------------------------------------------------
module pp_row_gen
    import mul_pkg::*;
#(
    parameter int W     = MUL_W,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             a_bit,
    input  logic [W-1:0]     b,
    input  logic [CNT_W-1:0] shift,
    output logic [2*W-1:0]   row
);

    logic [2*W-1:0] b_wide;

    assign b_wide = {{W{1'b0}}, b};
    assign row    = a_bit ? (b_wide << shift) : '0;

endmodule

// File: rtl/mul_seq_accum.sv
// -----------------------------------------------------------------------------
// mul_seq_accum: shift-and-add multiplier, one partial-product row per cycle.
//
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : operand pair on a/b is valid
//   in_ready   : block accepts operands (high only in IDLE)
//   a, b       : multiplier / multiplicand (W bits)
//   out_valid  : result holds a completed product
//   out_ready  : consumer accepts the result
//   result     : unsigned product a*b (2W bits), qualify with out_valid
//   busy       : high while accumulating rows
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once out_valid rises, result and out_valid hold until the edge
// where out_ready is high; nothing times out. Operands are accepted only in
// IDLE, and a DONE->IDLE return never accepts new operands on the same edge.
//
// Optional build macro MUL_SEQ_EARLY_TERM_EN: leave ACCUM as soon as the
// remaining multiplier bits are all zero (a = 0 goes straight to DONE).
// Products are identical; only latency changes.
// -----------------------------------------------------------------------------
module mul_seq_accum
    import mul_pkg::*;
#(
    parameter int W     = MUL_W,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           busy
);

    mul_state_t       state;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   row;
    logic             last_row;

    pp_row_gen #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_pp_row_gen (
        .a_bit (a_reg[0]),
        .b     (b_reg),
        .shift (cnt),
        .row   (row)
    );

    // The row added this cycle is the last one: either all W rows are done,
    // or (early termination) no set multiplier bits remain after the shift.
`ifdef MUL_SEQ_EARLY_TERM_EN
    assign last_row = (cnt == CNT_W'(W - 1)) || (a_reg[W-1:1] == '0);
`else
    assign last_row = (cnt == CNT_W'(W - 1));
`endif

    // acc is never cleared on the way back to IDLE, so result keeps the
    // last product there; consumers look at it only under out_valid.
    assign result = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
`ifdef MUL_SEQ_EARLY_TERM_EN
                        if (a == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                            busy  <= 1'b1;
                        end
`else
                        state <= ACCUM;
                        busy  <= 1'b1;
`endif
                    end
                end

                ACCUM: begin
                    // 2W-bit sum of W-bit-by-W-bit rows cannot overflow.
                    acc   <= acc + row;
                    a_reg <= a_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_row) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_accum.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_accum: self-checking bench for mul_seq_accum.
// Inputs change on the falling edge; the monitor samples 1 time unit after
// the falling edge. Expected products and latencies come from plain
// arithmetic on the operands and are queued when operands are issued.
// -----------------------------------------------------------------------------
module tb_mul_seq_accum;
    import mul_pkg::*;

    localparam int W  = MUL_W;
    localparam int PW = MUL_PW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] result;
    logic          busy;

    always #5 clk = ~clk;

    mul_seq_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    int             n_total = 0;
    int             n_bad   = 0;
    logic [PW-1:0]  exp_q[$];
    int             lat_q[$];
    int             cyc = 0;
    int             accept_cyc = 0;
    logic           prev_valid = 1'b0;
    logic           rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: edges from the accept edge (counted as 1) to out_valid.
    function automatic int model_lat(input logic [W-1:0] av);
`ifdef MUL_SEQ_EARLY_TERM_EN
        if (av == '0) return 1;
        for (int i = W - 1; i >= 0; i--) begin
            if (av[i]) return i + 2;
        end
        return 1;
`else
        return W + 1;
`endif
    endfunction

    function automatic logic [PW-1:0] model_prod(input logic [W-1:0] av, input logic [W-1:0] bv);
        return PW'(av) * PW'(bv);
    endfunction

    // Edge counter and accept-edge recorder.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) accept_cyc <= cyc + 1;
    end

    // Monitor: latency on the rising out_valid, product on each handshake.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                check("out_expected", (lat_q.size() != 0), 1);
                if (lat_q.size() != 0) check("latency", cyc - accept_cyc + 1, lat_q[0]);
            end
            if (out_valid && out_ready) begin
                check("result_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("result", result, exp_q.pop_front());
                    if (lat_q.size() != 0) void'(lat_q.pop_front());
                end
            end
            prev_valid <= out_valid;
        end
    end

    // Random back-pressure generator.
    always @(negedge clk) begin
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", in_ready, 1);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        wait_ready();
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        exp_q.push_back(model_prod(av, bv));
        lat_q.push_back(model_lat(av));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int k;
        int prev_acc;
        logic [W-1:0] prev_a;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic product, in_ready low for the whole operation.
        issue(6'd5, 6'd3);
        check("busy_accum", busy, 1);
        lat = model_lat(6'd5);
        for (int i = 0; i < lat; i++) begin
            check("in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        check("in_ready_back", in_ready, 1);

        // Boundaries: full-scale operands and a zero multiplier.
        issue(6'd63, 6'd63);
        issue(6'd0, 6'd63);
        issue(6'd1, 6'd9);
        issue(6'd32, 6'd0);
        drain();

        // Stall with out_ready low; in_valid pulses must be ignored.
        out_ready = 1'b0;
        issue(6'd12, 6'd10);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("stall_valid_wait", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("stall_result", result, 120);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            in_valid = ~in_valid;
            a        = W'($urandom);
            b        = W'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_idle", in_ready, 1);
        check("release_valid", out_valid, 0);
        drain();

        // Asynchronous reset three cycles into ACCUM.
        issue(6'd33, 6'd21);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(6'd2, 6'd2);
        drain();

        // Back-to-back with in_valid held high.
        in_valid = 1'b1;
        prev_acc = 0;
        prev_a   = '0;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            ra = W'($urandom);
            rb = W'($urandom);
            a  = ra;
            b  = rb;
            exp_q.push_back(model_prod(ra, rb));
            lat_q.push_back(model_lat(ra));
            @(posedge clk);
            #1;
            if (i > 0) check("accept_spacing", accept_cyc - prev_acc, model_lat(prev_a) + 1);
            prev_acc = accept_cyc;
            prev_a   = ra;
        end
        in_valid = 1'b0;
        @(negedge clk);
        drain();

        // Random operands with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            issue(W'($urandom), W'($urandom));
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
